// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: valid/ready request front end for a single-port masked-write SRAM macro (RW0 port).
// Latency: a read accepted in cycle T presents resp_valid/resp_rdata in cycle T+2; writes give no response.
// Backpressure: req_ready drops in the read-inflight cycle and while a response is held unconsumed.
//
// Ports:
//   clock, reset                   single clock, synchronous active-high reset
//   req_valid/req_ready            request handshake; req_write selects write (1) or read (0)
//   req_addr, req_wmask, req_wdata request address, per-segment write mask, write data
//   resp_valid/resp_ready          read-response handshake; resp_rdata held until consumed
//   init_done                      array is ready for traffic
//   sram_en/wmode/addr/wmask/wdata drive the macro's RW0 port; sram_rdata is its read data
//
// Build option: define SRAM_PORT_CTRL_INIT_EN to zero-fill the whole array after every reset
// before any request is accepted. Left undefined, there is no sweep and init_done is constant 1.
module sram_port_ctrl #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 1316,
  parameter int SEGS   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [SEGS-1:0]   req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [SEGS-1:0]   sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  // Geometry sanity: the sweep relies on DEPTH filling the address space exactly,
  // and the macro mask splits the word into equal segments.
  if (DEPTH != (1 << ADDR_W) || (DATA_W % SEGS) != 0) begin : g_bad_cfg
    $error("sram_port_ctrl: DEPTH must equal 2**ADDR_W and DATA_W must be divisible by SEGS");
  end

  logic              init_busy;
  logic [ADDR_W-1:0] sweep_addr;
  logic              inflight;
  logic              accept;
  logic [DATA_W-1:0] resp_q;

`ifdef SRAM_PORT_CTRL_INIT_EN
  // Zero-fill sweep: one full-mask write per cycle from address 0 up to DEPTH-1,
  // restarted from 0 by every reset, including one that lands mid-sweep.
  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } init_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  init_state_t       init_state;
  init_state_t       init_state_nxt;
  logic [ADDR_W-1:0] init_addr;
  logic [ADDR_W-1:0] init_addr_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      init_state <= ST_SWEEP;
      init_addr  <= '0;
    end else begin
      init_state <= init_state_nxt;
      init_addr  <= init_addr_nxt;
    end
  end

  always_comb begin
    init_state_nxt = init_state;
    init_addr_nxt  = init_addr;
    if (init_state == ST_SWEEP) begin
      // The address wraps to 0 after the last entry; it is not looked at again.
      init_addr_nxt = init_addr + 1'b1;
      if (init_addr == LAST_ADDR) begin
        init_state_nxt = ST_RUN;
      end
    end
  end

  assign init_busy  = (init_state == ST_SWEEP);
  assign sweep_addr = init_addr;
`else
  assign init_busy  = 1'b0;
  assign sweep_addr = '0;
`endif

  assign init_done = !init_busy;

  // One rule for reads and writes: nothing while sweeping, nothing in the cycle the
  // macro is returning read data, and nothing while a response would be overwritten.
  assign req_ready = init_done && !inflight && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;

  // Macro port. When idle the data-side outputs simply follow the request inputs so they
  // are never X; only sram_en qualifies the cycle. The port is silenced during reset.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = req_write;
    sram_addr  = req_addr;
    sram_wmask = req_wmask;
    sram_wdata = req_wdata;
    if (init_busy) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = sweep_addr;
      sram_wmask = '1;
      sram_wdata = '0;
    end else if (accept) begin
      sram_en = 1'b1;
    end
    if (reset) begin
      sram_en = 1'b0;
    end
  end

  // inflight marks the cycle in which the macro drives the read data of last cycle's read.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight   <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      inflight <= accept && !req_write;
      if (inflight) begin
        resp_valid <= 1'b1;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // Response data register is deliberately unreset; resp_valid qualifies it.
  // sram_rdata is garbage outside the inflight cycle, so it is sampled only then.
  always_ff @(posedge clock) begin
    if (!reset && inflight) begin
      resp_q <= sram_rdata;
    end
  end

  assign resp_rdata = resp_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: randomized self-checking bench for sram_port_ctrl with a behavioural SRAM macro.
// Inputs are driven 1 time unit after the rising edge and outputs sampled 1-2 units later.
// A word-level reference memory plus response model gives every expected value.
module tb_sram_port_ctrl;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 1316;
  localparam int SEGS   = 4;
  localparam int SEG_W  = DATA_W / SEGS;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [SEGS-1:0]   req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [SEGS-1:0]   sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                known   [DEPTH];
  logic [DATA_W-1:0] mem     [DEPTH];

  sram_port_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEGS(SEGS)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < DATA_W; i += 32) w = (w << 32) | DATA_W'($urandom);
    return w;
  endfunction

  // Behavioural macro: masked write, registered read; read data is random junk otherwise.
  always @(posedge clock) begin
    if (sram_en && sram_wmode) begin
      for (int s = 0; s < SEGS; s++)
        if (sram_wmask[s]) mem[sram_addr][s*SEG_W +: SEG_W] <= sram_wdata[s*SEG_W +: SEG_W];
    end
    if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
    else                        sram_rdata <= rand_word();
  end

  // Reference memory update: masked-in segments take the new data.
  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [SEGS-1:0] m,
                             input logic [DATA_W-1:0] d);
    for (int s = 0; s < SEGS; s++)
      if (m[s]) ref_mem[a][s*SEG_W +: SEG_W] = d[s*SEG_W +: SEG_W];
    if (m == '1) known[a] = 1'b1;
  endtask

  task automatic model_zero_all();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      known[i]   = 1'b1;
    end
  endtask

  // Present a request, wait (bounded) for acceptance, return at +1 of the cycle after accept.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [SEGS-1:0] m,
                       input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wmask = m; req_wdata = d;
    #1;
    while (req_ready !== 1'b1 && n < 400) begin
      @(posedge clock); #2; n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_wait: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end else if (wr) begin
      model_write(a, m, d);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h09;
    req_wmask = '1; req_wdata = rand_word(); resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #2;
`ifdef SRAM_PORT_CTRL_INIT_EN
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b, required 0", init_done); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
`else
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reset_init_done: got %b, required 1", init_done); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b, required 1", req_ready); end
`endif
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b, required 0", resp_valid); end
    checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL reset_sram_en: got %b, required 0", sram_en); end
    @(posedge clock); #1;
  endtask

`ifdef SRAM_PORT_CTRL_INIT_EN
  task automatic test_init();
    int bad;
    bad = 0;
    reset = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 7'd5;
    #1;
    for (int c = 0; c < DEPTH; c++) begin
      checks++;
      if (req_ready !== 1'b0 || init_done !== 1'b0 || sram_en !== 1'b1 || sram_wmode !== 1'b1 ||
          sram_addr !== ADDR_W'(c) || sram_wmask !== '1 || sram_wdata !== '0) begin
        errors++; bad++;
        if (bad < 5)
          $display("FAIL init_sweep cycle %0d: rdy=%b done=%b en=%b wmode=%b addr=%0d mask=%b, required 0 0 1 1 %0d 1111 wdata=0",
                   c, req_ready, init_done, sram_en, sram_wmode, sram_addr, sram_wmask, c);
      end
      @(posedge clock); #2;
    end
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || sram_en !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== 7'd5) begin
      errors++;
      $display("FAIL init_first_accept: done=%b rdy=%b en=%b wmode=%b addr=%0d, required 1 1 1 0 5",
               init_done, req_ready, sram_en, sram_wmode, sram_addr);
    end
    model_zero_all();
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #2;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== '0) begin
      errors++;
      $display("FAIL init_read5: valid=%b rdata_lo=%h, required 1 and zero", resp_valid, resp_rdata[63:0]);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_sweep();
    int n;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (60) @(posedge clock);
    #2;
    checks++;
    if (sram_en !== 1'b1 || sram_addr !== 7'd60) begin
      errors++; $display("FAIL sweep_at60: en=%b addr=%0d, required 1 60", sram_en, sram_addr);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (sram_addr !== 7'd0 || sram_en !== 1'b1) begin
      errors++; $display("FAIL sweep_restart: en=%b addr=%0d, required 1 0", sram_en, sram_addr);
    end
    n = 0;
    while (init_done !== 1'b1 && n < 400) begin
      @(posedge clock); #2; n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL sweep_done_time: init_done after %0d cycles, required %0d", n, DEPTH);
    end
    model_zero_all();
    @(posedge clock); #1;
  endtask
`else
  task automatic test_no_init();
    logic [DATA_W-1:0] w;
    w = rand_word();
    reset = 1'b0; resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd3; req_wmask = '1; req_wdata = w;
    #1;
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 7'd3) begin
      errors++;
      $display("FAIL no_init_first_write: done=%b rdy=%b en=%b wmode=%b addr=%0d, required 1 1 1 1 3",
               init_done, req_ready, sram_en, sram_wmode, sram_addr);
    end
    model_write(7'd3, '1, w);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask
`endif

  task automatic test_write_read();
    logic [DATA_W-1:0] a_pat;
    a_pat = rand_word();
    resp_ready = 1'b1;
    issue(1'b1, 7'h12, 4'b1111, a_pat);
    issue(1'b0, 7'h12, '0, '0);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL wr_rd_t1: valid=%b rdy=%b, required 0 0", resp_valid, req_ready);
    end
    @(posedge clock); #2;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== a_pat) begin
      errors++; $display("FAIL wr_rd_t2: valid=%b rdata_lo=%h, required 1 %h", resp_valid, resp_rdata[63:0], a_pat[63:0]);
    end
    @(posedge clock); #2;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL wr_rd_consumed: valid=%b, required 0", resp_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_masked();
    logic [DATA_W-1:0] b_pat, c_pat, exp_w;
    b_pat = rand_word();
    c_pat = rand_word();
    exp_w = b_pat;
    exp_w[0*SEG_W +: SEG_W] = c_pat[0*SEG_W +: SEG_W];
    exp_w[2*SEG_W +: SEG_W] = c_pat[2*SEG_W +: SEG_W];
    issue(1'b1, 7'h33, 4'b1111, b_pat);
    issue(1'b1, 7'h33, 4'b0101, c_pat);
    issue(1'b0, 7'h33, '0, '0);
    @(posedge clock); #2;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== exp_w) begin
      errors++; $display("FAIL masked_write: valid=%b rdata_lo=%h, required 1 %h", resp_valid, resp_rdata[63:0], exp_w[63:0]);
    end
    checks++;
    if (ref_mem[7'h33] !== exp_w) begin
      errors++; $display("FAIL masked_model: model_lo=%h, required %h", ref_mem[7'h33][63:0], exp_w[63:0]);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d_pat, e_pat;
    d_pat = rand_word();
    e_pat = rand_word();
    resp_ready = 1'b1;
    issue(1'b1, 7'h40, '1, d_pat);
    issue(1'b1, 7'h41, '1, e_pat);
    resp_ready = 1'b0;
    issue(1'b0, 7'h40, '0, '0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h41;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_inflight_rdy: got %b, required 0", req_ready); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #2;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== d_pat || req_ready !== 1'b0 || sram_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b rdy=%b en=%b rdata_lo=%h, required 1 0 0 %h",
                 k, resp_valid, req_ready, sram_en, resp_rdata[63:0], d_pat[63:0]);
      end
    end
    @(posedge clock); #2;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || sram_en !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== 7'h41 || resp_rdata !== d_pat) begin
      errors++;
      $display("FAIL bp_release: rdy=%b en=%b wmode=%b addr=%h rdata_lo=%h, required 1 1 0 41 %h",
               req_ready, sram_en, sram_wmode, sram_addr, resp_rdata[63:0], d_pat[63:0]);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_e_inflight: valid=%b, required 0", resp_valid); end
    @(posedge clock); #2;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== e_pat) begin
      errors++; $display("FAIL bp_e_return: valid=%b rdata_lo=%h, required 1 %h", resp_valid, resp_rdata[63:0], e_pat[63:0]);
    end
    @(posedge clock); #1;
  endtask

  // Cycle-level random traffic against a transaction model: a read accepted in cycle t
  // shows up from t+2 until consumed; requests are refused in the cycle after a read and
  // while an unconsumed response is held.
  task automatic test_random();
    logic              m_inflight, m_valid, acc, wr, exp_rdy;
    logic [DATA_W-1:0] m_data, m_pending, d;
    logic [ADDR_W-1:0] a;
    logic [SEGS-1:0]   m;
    int                bad;
    bad = 0;
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    m_inflight = 1'b0; m_valid = 1'b0; m_data = '0; m_pending = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      a  = ADDR_W'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      m  = SEGS'($urandom);
      d  = rand_word();
      if (!known[a]) begin wr = 1'b1; m = '1; end
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = wr; req_addr = a; req_wmask = m; req_wdata = d;
      resp_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !m_inflight && (!m_valid || resp_ready);
      acc     = req_valid && exp_rdy;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; bad++;
        if (bad < 8) $display("FAIL rand_req_ready cycle %0d: got %b, required %b", cyc, req_ready, exp_rdy);
      end
      checks++;
      if (resp_valid !== m_valid || (m_valid && resp_rdata !== m_data)) begin
        errors++; bad++;
        if (bad < 8) $display("FAIL rand_resp cycle %0d: valid=%b rdata_lo=%h, required %b %h",
                              cyc, resp_valid, resp_rdata[63:0], m_valid, m_data[63:0]);
      end
      checks++;
      if (sram_en !== acc || (acc && (sram_wmode !== wr || sram_addr !== a))) begin
        errors++; bad++;
        if (bad < 8) $display("FAIL rand_sram_port cycle %0d: en=%b wmode=%b addr=%0d, required %b %b %0d",
                              cyc, sram_en, sram_wmode, sram_addr, acc, wr, a);
      end
      if (m_inflight) begin
        m_valid = 1'b1;
        m_data  = m_pending;
      end else if (m_valid && resp_ready) begin
        m_valid = 1'b0;
      end
      m_inflight = acc && !wr;
      if (acc && !wr) m_pending = ref_mem[a];
      if (acc && wr)  model_write(a, m, d);
      @(posedge clock); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n;
    seen = 1'b0;
    resp_ready = 1'b1;
    issue(1'b0, 7'h12, '0, '0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
`ifdef SRAM_PORT_CTRL_INIT_EN
    checks++;
    if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 7'd0) begin
      errors++; $display("FAIL mid_reset_sweep: en=%b wmode=%b addr=%0d, required 1 1 0", sram_en, sram_wmode, sram_addr);
    end
    n = 0;
    while (init_done !== 1'b1 && n < 400) begin
      if (resp_valid !== 1'b0) seen = 1'b1;
      @(posedge clock); #2; n++;
    end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL mid_reset_done: after %0d cycles, required %0d", n, DEPTH); end
    model_zero_all();
`else
    checks++;
    if (req_ready !== 1'b1 || init_done !== 1'b1) begin
      errors++; $display("FAIL mid_reset_ready: rdy=%b done=%b, required 1 1", req_ready, init_done);
    end
    for (int k = 0; k < 3; k++) begin
      if (resp_valid !== 1'b0) seen = 1'b1;
      @(posedge clock); #2;
    end
`endif
    checks++;
    if (seen || resp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_resp: resp_valid rose after reset (now %b), required 0", resp_valid);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      known[i]   = 1'b0;
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wmask = '0; req_wdata = '0; resp_ready = 1'b0;
    @(posedge clock); #1;
    test_reset();
`ifdef SRAM_PORT_CTRL_INIT_EN
    test_init();
`else
    test_no_init();
`endif
    test_write_read();
    test_masked();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef SRAM_PORT_CTRL_INIT_EN
    test_reset_sweep();
`endif
    test_write_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
